pipe_result_fifo: RTL and testbench

- Downstream capture stage for the three-stage arithmetic pipeline. The pipeline has no valid or stall signals, so this block is required to consume its F output.
- Tracks which pipeline slots carry real operands using a valid delay line matched to the pipeline latency. Captures F into a small FIFO when it emerges, then presents results to the consumer over a valid/ready handshake.
- Issues a credit signal upstream so that operands are only launched when FIFO space is guaranteed.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/sync_fifo_sa.sv | 46 ++++
 rtl/pipe_result_fifo.sv | 48 ++++
 tb/tb_pipe_result_fifo.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: constants shared by the arithmetic pipeline and its result capture stage
package pipe_pkg;
    localparam int DATA_W   = 10;
    localparam int PIPE_LAT = 2;
    function automatic int clog2_safe(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/sync_fifo_sa.sv
// sync_fifo_sa: show-ahead FIFO; dout is the head entry, or the last popped word when empty
module sync_fifo_sa
    import pipe_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [W-1:0]                  din,
    output logic [W-1:0]                  dout,
    output logic [clog2_safe(DEPTH):0]    count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = clog2_safe(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  last_q;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          wr_en, rd_en;
    assign empty = count == '0;
    assign full  = count == (AW + 1)'(DEPTH);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = empty ? last_q : mem[rd_ptr];
    // storage: a full FIFO still accepts a write when the head leaves on the same edge
    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= din;
    // pointers wrap naturally at DEPTH; occupancy kept separately to tell full from empty
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            count <= (wr_en && !rd_en) ? count + 1'b1 : (rd_en && !wr_en) ? count - 1'b1 : count;
        end
endmodule

// File: rtl/pipe_result_fifo.sv
// pipe_result_fifo: tracks live pipeline slots, captures F into a FIFO and issues upstream credit
module pipe_result_fifo
    import pipe_pkg::*;
#(
    parameter int N     = DATA_W,
    parameter int LAT   = PIPE_LAT,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue,
    input  logic [N-1:0]               f_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_data,
    output logic                       can_issue,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int CW = $clog2(DEPTH) + 2;
    logic [LAT-1:0] vld;
    logic [CW-1:0]  inflight;
    logic           push, pop, full, empty;
    assign push      = vld[LAT-1];
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign inflight  = CW'($countones(vld));
    assign can_issue = (CW'(count) + inflight) < CW'(DEPTH);
    // valid delay line: an issue shifts in and reaches the top bit when its F is ready
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) vld <= '0;
        else        vld <= LAT'({vld, issue});
    // sticky error: issuing without credit, or a result arriving with nowhere to go
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) overflow <= 1'b0;
        else if ((issue && !can_issue) || (push && full && !pop)) overflow <= 1'b1;
    sync_fifo_sa #(.W(N), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (f_in),
        .dout  (out_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_pipe_result_fifo.sv
// tb_pipe_result_fifo: scenario tasks checked against a queue-based model of the capture stage
module tb_pipe_result_fifo;
    import pipe_pkg::*;
    localparam int N     = DATA_W;
    localparam int LAT   = PIPE_LAT;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    logic clk = 1'b0, rst_n = 1'b0, issue = 1'b0, out_ready = 1'b0;
    logic [N-1:0]  f_in = '0;
    logic          out_valid, can_issue, overflow;
    logic [N-1:0]  out_data;
    logic [CW-1:0] count;
    int errors = 0, checks = 0;
    int edge_n = 0;
    int due[$];
    logic [N-1:0] q[$];
    bit m_ovf = 1'b0;
    always #5 clk = ~clk;
    pipe_result_fifo #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .f_in      (f_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .can_issue (can_issue),
        .count     (count),
        .overflow  (overflow)
    );
    function automatic bit m_can();
        return (q.size() + due.size()) < DEPTH;
    endfunction
    task automatic tick(input bit iss, input logic [N-1:0] f, input bit rdy);
        bit can_b, full_b, pop_m, push_m;
        issue = iss; f_in = f; out_ready = rdy;
        can_b  = m_can();
        full_b = q.size() == DEPTH;
        pop_m  = q.size() != 0 && rdy;
        @(posedge clk);
        edge_n++;
        push_m = due.size() != 0 && due[0] == edge_n;
        if (push_m) void'(due.pop_front());
        if (iss && !can_b) m_ovf = 1'b1;
        if (pop_m) void'(q.pop_front());
        if (push_m) begin
            if (!full_b || pop_m) q.push_back(f);
            else m_ovf = 1'b1;
        end
        if (iss) due.push_back(edge_n + LAT);
        #1;
        issue = 1'b0;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %0d want 0", out_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (can_issue !== 1'b1) begin errors++; $display("FAIL reset_can_issue: got %b want 1", can_issue); end
        @(negedge clk) rst_n = 1'b1;
    endtask
    task automatic test_single();
        tick(1'b1, N'($urandom), 1'b1);
        tick(1'b0, N'($urandom), 1'b1);
        tick(1'b0, N'(28), 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== N'(28)) begin errors++; $display("FAIL single_data: got %0d want 28", out_data); end
        checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL single_count1: got %0d want %0d", count, q.size()); end
        tick(1'b0, N'($urandom), 1'b1);
        checks++; if (count !== CW'(q.size()) || out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got count=%0d valid=%b want count=%0d valid=0", count, out_valid, q.size()); end
    endtask
    task automatic test_back_to_back();
        logic [N-1:0] vals [4] = '{N'(28), N'(21), N'(40), N'(7)};
        for (int i = 0; i < 6; i++) tick(i < 4, i >= 2 ? vals[i-2] : N'($urandom), 1'b0);
        checks++; if (count !== CW'(4)) begin errors++; $display("FAIL b2b_count: got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin errors++; $display("FAIL b2b_data%0d: got valid=%b data=%0d want valid=1 data=%0d", i, out_valid, out_data, vals[i]); end
            tick(1'b0, N'($urandom), 1'b1);
        end
        checks++; if (count !== '0) begin errors++; $display("FAIL b2b_empty: got %0d want 0", count); end
    endtask
    task automatic test_credit_stall();
        int issued = 0;
        bit iss;
        for (int i = 0; i < 12; i++) begin
            checks++; if (can_issue !== m_can()) begin errors++; $display("FAIL credit_can_issue%0d: got %b want %b", i, can_issue, m_can()); end
            iss = m_can();
            issued += int'(iss);
            tick(iss, N'($urandom), 1'b0);
        end
        repeat (LAT) tick(1'b0, N'($urandom), 1'b0);
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL credit_count: got %0d want %0d (issued %0d)", count, DEPTH, issued); end
        checks++; if (can_issue !== 1'b0) begin errors++; $display("FAIL credit_full_can_issue: got %b want 0", can_issue); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL credit_overflow: got %b want 0", overflow); end
    endtask
    task automatic test_full_push_pop();
        logic [N-1:0] head;
        tick(1'b1, N'($urandom), 1'b0);
        repeat (LAT - 1) tick(1'b0, N'($urandom), 1'b0);
        head = q[0];
        tick(1'b0, N'('h3A5), 1'b1);
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fullpp_count: got %0d want %0d", count, DEPTH); end
        checks++; if (out_data !== q[0] || out_data === head) begin errors++; $display("FAIL fullpp_head: got %0d want %0d", out_data, q[0]); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL fullpp_overflow: got %b want %b", overflow, m_ovf); end
    endtask
    task automatic test_overflow();
        tick(1'b1, N'($urandom), 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        repeat (LAT - 1) tick(1'b0, N'($urandom), 1'b0);
        tick(1'b0, N'('h155), 1'b0);
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d want %0d", count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (q.size() == 0 || out_data !== q[0]) begin errors++; $display("FAIL ovf_drain%0d: got %0h want %0h", i, out_data, q.size() ? q[0] : N'(0)); end
            tick(1'b0, N'($urandom), 1'b1);
        end
        checks++; if (count !== '0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got count=%0d ovf=%b want count=0 ovf=1", count, overflow); end
    endtask
    task automatic test_reset_midstream();
        repeat (7) tick(1'b1, N'($urandom), 1'b0);
        checks++; if (count !== CW'(5)) begin errors++; $display("FAIL mid_pre_count: got %0d want 5", count); end
        #3 rst_n = 1'b0;
        #1;
        q.delete(); due.delete(); m_ovf = 1'b0;
        checks++; if (count !== '0) begin errors++; $display("FAIL mid_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL mid_out: got valid=%b data=%0d want 0/0", out_valid, out_data); end
        checks++; if (overflow !== 1'b0 || can_issue !== 1'b1) begin errors++; $display("FAIL mid_flags: got ovf=%b can=%b want 0/1", overflow, can_issue); end
        @(negedge clk) rst_n = 1'b1;
        repeat (LAT + 2) tick(1'b0, N'($urandom), 1'b0);
        checks++; if (count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_push: got count=%0d valid=%b want 0/0", count, out_valid); end
    endtask
    task automatic test_random();
        bit iss;
        for (int i = 0; i < 400; i++) begin
            iss = ($urandom_range(0, 2) != 0) && m_can();
            tick(iss, N'($urandom), 1'($urandom_range(0, 1)));
            checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL rand_count%0d: got %0d want %0d", i, count, q.size()); end
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid%0d: got %b want %b", i, out_valid, q.size() != 0); end
            checks++; if (can_issue !== m_can()) begin errors++; $display("FAIL rand_can%0d: got %b want %b", i, can_issue, m_can()); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf%0d: got %b want %b", i, overflow, m_ovf); end
            if (q.size() != 0) begin
                checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rand_data%0d: got %0h want %0h", i, out_data, q[0]); end
            end
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_credit_stall();
        test_full_push_pop();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
